// File: rtl/wmem_port_arbiter_pkg.sv
// wmem_port_arbiter_pkg: shared encodings and defaults for the weight-memory port arbiter.
package wmem_port_arbiter_pkg;
  localparam int WM_AW_DEF = 32;
  localparam int WM_DW_DEF = 64;
  localparam int BURST_LEN_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_PS = 2'd1, OWN_CU = 2'd2, DRAIN = 2'd3} state_t;
  typedef enum logic {OWN_ID_PS = 1'b0, OWN_ID_CU = 1'b1} owner_t;
  function automatic owner_t rr_pick(input logic ps, input logic cu, input owner_t last);
    return (ps && (!cu || last == OWN_ID_CU)) ? OWN_ID_PS : OWN_ID_CU;
  endfunction
endpackage

// File: rtl/wmem_port_arbiter_if.sv
// wmem_port_arbiter_if: PS write-burst, CU read-burst and weight-memory signals of the arbiter.
interface wmem_port_arbiter_if
  import wmem_port_arbiter_pkg::*;
#(
  parameter int AW = WM_AW_DEF,
  parameter int DW = WM_DW_DEF,
  parameter int LW = BURST_LEN_W_DEF
);
  logic ps_req;
  logic [AW-1:0] ps_addr;
  logic [LW-1:0] ps_len;
  logic ps_gnt;
  logic ps_wvalid;
  logic [DW-1:0] ps_wdata;
  logic ps_wready;
  logic ps_done;
  logic cu_req;
  logic [AW-1:0] cu_addr;
  logic [LW-1:0] cu_len;
  logic cu_gnt;
  logic [DW-1:0] cu_rdata;
  logic cu_rvalid;
  logic cu_done;
  logic wm_ce;
  logic wm_we;
  logic [AW-1:0] wm_addr;
  logic [DW-1:0] wm_din;
  logic [DW-1:0] wm_dout;
  modport master (
    output ps_req, ps_addr, ps_len, ps_wvalid, ps_wdata, cu_req, cu_addr, cu_len, wm_dout,
    input ps_gnt, ps_wready, ps_done, cu_gnt, cu_rdata, cu_rvalid, cu_done,
    input wm_ce, wm_we, wm_addr, wm_din
  );
  modport slave (
    input ps_req, ps_addr, ps_len, ps_wvalid, ps_wdata, cu_req, cu_addr, cu_len, wm_dout,
    output ps_gnt, ps_wready, ps_done, cu_gnt, cu_rdata, cu_rvalid, cu_done,
    output wm_ce, wm_we, wm_addr, wm_din
  );
endinterface

// File: rtl/wmem_burst_agen.sv
// wmem_burst_agen: burst address generator with beats-left counter, reloaded on every grant.
module wmem_burst_agen
  import wmem_port_arbiter_pkg::*;
#(
  parameter int AW = WM_AW_DEF,
  parameter int LW = BURST_LEN_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  input  logic          i_step,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_left;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_left <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + AW'(1);
      r_left <= r_left - LW'(1);
    end
  end
  assign o_addr = r_addr;
  assign o_last = r_left == '0;
endmodule

// File: rtl/wmem_port_arbiter.sv
// wmem_port_arbiter: round-robin, burst-granular owner of the single weight-memory port.
module wmem_port_arbiter
  import wmem_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE_WMEMORY = WM_AW_DEF,
  parameter int DATA_WIDTH_WMEMORY = WM_DW_DEF,
  parameter int BURST_LEN_W = BURST_LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      glb_enable,
  wmem_port_arbiter_if.slave        bus,
  output logic                      abort,
  output logic [1:0]                state_out
);
  state_t r_state, w_next;
  owner_t r_last, w_win;
  logic r_abt, r_ce, r_we, r_rd_pend, r_ps_done, r_cu_done, r_abort;
  logic [ADDRESS_SIZE_WMEMORY-1:0] r_addr, w_cur;
  logic [DATA_WIDTH_WMEMORY-1:0] r_din;
  logic w_load, w_ps_beat, w_cu_issue, w_step, w_last, w_ps_done, w_cu_done, w_abort;
  wmem_burst_agen #(.AW(ADDRESS_SIZE_WMEMORY), .LW(BURST_LEN_W)) u_agen (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_base (w_win == OWN_ID_PS ? bus.ps_addr : bus.cu_addr),
    .i_len  (w_win == OWN_ID_PS ? bus.ps_len : bus.cu_len),
    .i_step (w_step),
    .o_addr (w_cur),
    .o_last (w_last)
  );
  always_comb begin
    w_next = r_state;
    w_win = rr_pick(bus.ps_req, bus.cu_req, r_last);
    w_load = 1'b0;
    w_ps_beat = 1'b0;
    w_cu_issue = 1'b0;
    w_ps_done = 1'b0;
    w_cu_done = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: if (glb_enable && (bus.ps_req || bus.cu_req)) begin
        w_load = 1'b1;
        w_next = w_win == OWN_ID_PS ? OWN_PS : OWN_CU;
      end
      OWN_PS: begin
        // a handshaken beat always lands, even on the cycle enable drops
        w_ps_beat = bus.ps_wvalid;
        if (!glb_enable) begin
          w_next = IDLE;
          w_abort = 1'b1;
        end else if (bus.ps_wvalid && w_last) begin
          w_next = IDLE;
          w_ps_done = 1'b1;
        end
      end
      OWN_CU: if (!glb_enable) begin
        w_next = DRAIN;
        w_abort = 1'b1;
      end else begin
        w_cu_issue = 1'b1;
        w_next = w_last ? DRAIN : OWN_CU;
      end
      DRAIN: begin
        w_next = IDLE;
        w_cu_done = !r_abt;
      end
      default: w_next = IDLE;
    endcase
    w_step = w_ps_beat | w_cu_issue;
  end
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= OWN_ID_CU;
      r_abt <= 1'b0;
      r_ce <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_din <= '0;
      r_rd_pend <= 1'b0;
      r_ps_done <= 1'b0;
      r_cu_done <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_last <= w_load ? w_win : r_last;
      r_abt <= w_abort | (r_abt & ~w_load);
      r_ce <= w_step;
      r_we <= w_ps_beat;
      r_addr <= w_step ? w_cur : '0;
      r_din <= w_ps_beat ? bus.ps_wdata : '0;
      r_rd_pend <= r_ce && !r_we;
      r_ps_done <= w_ps_done;
      r_cu_done <= w_cu_done;
      r_abort <= w_abort;
    end
  end
  assign bus.ps_gnt = r_state == OWN_PS;
  assign bus.ps_wready = r_state == OWN_PS;
  assign bus.ps_done = r_ps_done;
  assign bus.cu_gnt = r_state == OWN_CU;
  assign bus.cu_rvalid = r_rd_pend;
  assign bus.cu_rdata = r_rd_pend ? bus.wm_dout : '0;
  assign bus.cu_done = r_cu_done;
  assign bus.wm_ce = r_ce;
  assign bus.wm_we = r_we;
  assign bus.wm_addr = r_addr;
  assign bus.wm_din = r_din;
  assign abort = r_abort;
  assign state_out = r_state;
endmodule

// File: tb/tb_wmem_port_arbiter.sv
// tb_wmem_port_arbiter: burst-level reference checks of the weight-memory port arbiter.
module tb_wmem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic glb_enable = 1'b0;
  logic abort;
  logic [1:0] state_out;
  int total = 0;
  int bad = 0;
  bit exp_last = 1'b1;
  logic [63:0] ref_m [logic [31:0]];
  logic [63:0] phys [logic [31:0]];
  typedef struct {
    bit preq; bit creq;
    logic [31:0] pa; logic [7:0] pl;
    logic [31:0] ca; logic [7:0] cl;
    logic [31:0] mask; logic [63:0] dbase;
    bit exp_cu;
  } vec_t;
  vec_t vt[8];
  wmem_port_arbiter_if #(.AW(32), .DW(64), .LW(8)) bus();
  wmem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .glb_enable (glb_enable),
    .bus        (bus),
    .abort      (abort),
    .state_out  (state_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.wm_ce) begin
      if (bus.wm_we) phys[bus.wm_addr] = bus.wm_din;
      else bus.wm_dout <= phys.exists(bus.wm_addr) ? phys[bus.wm_addr] : 64'd0;
    end
  end
  function automatic logic [63:0] refrd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : 64'd0;
  endfunction
  function automatic logic [31:0] rnd_addr();
    return ($urandom % 4 == 0) ? 32'hFFFF_FFFC + ($urandom % 4) : 32'h200 + ($urandom % 16);
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_mutex", 64'(bus.ps_gnt & bus.cu_gnt), 0);
    chk("we_without_ce", 64'(bus.wm_we & ~bus.wm_ce), 0);
  endtask
  task automatic chk_zero();
    chk("z_ps_gnt", bus.ps_gnt, 0);
    chk("z_ps_wready", bus.ps_wready, 0);
    chk("z_ps_done", bus.ps_done, 0);
    chk("z_cu_gnt", bus.cu_gnt, 0);
    chk("z_cu_rvalid", bus.cu_rvalid, 0);
    chk("z_cu_rdata", bus.cu_rdata, 0);
    chk("z_cu_done", bus.cu_done, 0);
    chk("z_abort", abort, 0);
    chk("z_wm_ce", bus.wm_ce, 0);
    chk("z_wm_we", bus.wm_we, 0);
    chk("z_wm_addr", bus.wm_addr, 0);
    chk("z_wm_din", bus.wm_din, 0);
    chk("z_state", state_out, 0);
  endtask
  task automatic burst(input bit preq, input bit creq, input logic [31:0] pa, input logic [7:0] pl,
                       input logic [31:0] ca, input logic [7:0] cl, input logic [31:0] mask,
                       input logic [63:0] dbase, input bit exp_cu, input int abort_at);
    logic [31:0] a;
    logic [63:0] pd;
    int n, k, bi;
    bit fin, v, ab, pv;
    glb_enable = 1'b1;
    bus.ps_req = preq; bus.cu_req = creq;
    bus.ps_addr = pa; bus.ps_len = pl; bus.cu_addr = ca; bus.cu_len = cl;
    tick();
    bus.ps_req = 1'b0; bus.cu_req = 1'b0;
    bus.ps_addr = ~pa; bus.ps_len = ~pl; bus.cu_addr = ~ca; bus.cu_len = ~cl;
    chk("gnt_state", state_out, exp_cu ? 2 : 1);
    chk("gnt_ps", bus.ps_gnt, !exp_cu);
    chk("gnt_cu", bus.cu_gnt, exp_cu);
    chk("gnt_wready", bus.ps_wready, !exp_cu);
    chk("gnt_ce", bus.wm_ce, 0);
    chk("gnt_pulses", {bus.ps_done, bus.cu_done, abort, bus.cu_rvalid}, 0);
    exp_last = exp_cu;
    fin = 1'b0; ab = 1'b0;
    if (!exp_cu) begin
      a = pa; n = int'(pl) + 1; bi = 0;
      for (int j = 0; j < 64 && !fin; j++) begin
        v = (j < 32) ? mask[j] : 1'b1;
        ab = (j == abort_at);
        glb_enable = !ab; bus.ps_wvalid = v; bus.ps_wdata = dbase + 64'(bi);
        tick();
        chk("ps_ce", bus.wm_ce, v);
        chk("ps_we", bus.wm_we, v);
        if (v) begin
          chk("ps_addr", bus.wm_addr, a);
          chk("ps_din", bus.wm_din, dbase + 64'(bi));
          ref_m[a] = dbase + 64'(bi);
          a++; n--; bi++;
        end
        fin = ab || n == 0;
        chk("ps_done", bus.ps_done, !ab && n == 0);
        chk("ps_abort", abort, ab);
        chk("ps_state", state_out, fin ? 0 : 1);
        chk("ps_gnt", bus.ps_gnt, !fin);
      end
      bus.ps_wvalid = 1'b0; glb_enable = 1'b1;
    end else begin
      a = ca; n = int'(cl) + 1; k = 0; pv = 1'b0; pd = '0;
      for (int j = 0; j < 16 && !fin; j++) begin
        ab = (j == abort_at);
        glb_enable = !ab;
        tick();
        chk("cu_ce", bus.wm_ce, !ab);
        chk("cu_we", bus.wm_we, 0);
        if (!ab) chk("cu_addr", bus.wm_addr, a);
        chk("cu_rvalid", bus.cu_rvalid, pv);
        if (pv) chk("cu_rdata", bus.cu_rdata, pd);
        if (!ab) begin
          pd = refrd(a); a++; k++;
        end
        pv = !ab;
        fin = ab || k == n;
        chk("cu_state", state_out, fin ? 3 : 2);
        chk("cu_gnt", bus.cu_gnt, !fin);
        chk("cu_abort", abort, ab);
        chk("cu_done_early", bus.cu_done, 0);
      end
      glb_enable = 1'b1;
      tick();
      chk("dr_state", state_out, 0);
      chk("dr_ce", bus.wm_ce, 0);
      chk("dr_rvalid", bus.cu_rvalid, pv);
      if (pv) chk("dr_rdata", bus.cu_rdata, pd);
      chk("dr_done", bus.cu_done, !ab);
      chk("dr_abort", abort, 0);
    end
  endtask
  initial begin
    int est[10] = '{1, 0, 2, 3, 0, 1, 0, 2, 3, 0};
    int epd[10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    int ecd[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    vt[0] = '{1, 0, 32'h10, 8'd3, 32'h0, 8'd0, 32'hFFFF_FFFF, 64'hA0, 1'b0};
    vt[1] = '{0, 1, 32'h0, 8'd0, 32'h10, 8'd3, 32'hFFFF_FFFF, 64'h0, 1'b1};
    vt[2] = '{1, 1, 32'h20, 8'd0, 32'h10, 8'd0, 32'hFFFF_FFFF, 64'h11, 1'b0};
    vt[3] = '{1, 1, 32'h21, 8'd0, 32'h20, 8'd0, 32'hFFFF_FFFF, 64'h22, 1'b1};
    vt[4] = '{1, 1, 32'h22, 8'd0, 32'h21, 8'd0, 32'hFFFF_FFFF, 64'h33, 1'b0};
    vt[5] = '{1, 1, 32'h23, 8'd0, 32'h20, 8'd3, 32'hFFFF_FFFF, 64'h44, 1'b1};
    vt[6] = '{1, 0, 32'hFFFF_FFFE, 8'd3, 32'h0, 8'd0, 32'hFFFF_FFFD, 64'hB0, 1'b0};
    vt[7] = '{0, 1, 32'h0, 8'd0, 32'hFFFF_FFFE, 8'd3, 32'hFFFF_FFFF, 64'h0, 1'b1};
    bus.ps_req = 0; bus.ps_addr = 0; bus.ps_len = 0; bus.ps_wvalid = 0; bus.ps_wdata = 0;
    bus.cu_req = 0; bus.cu_addr = 0; bus.cu_len = 0; bus.wm_dout = 0;
    repeat (3) tick();
    chk_zero();
    reset = 1'b1;
    // both requesters held: PS wins the first tie, then ownership alternates
    glb_enable = 1'b1;
    bus.ps_req = 1; bus.cu_req = 1; bus.ps_addr = 32'h300; bus.cu_addr = 32'h300;
    bus.ps_wvalid = 1; bus.ps_wdata = 64'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_state", state_out, est[i]);
      chk("hold_ps_done", bus.ps_done, epd[i]);
      chk("hold_cu_done", bus.cu_done, ecd[i]);
      if (ecd[i] != 0) chk("hold_rdata", bus.cu_rdata, 64'h55);
    end
    bus.ps_req = 0; bus.cu_req = 0; bus.ps_wvalid = 0;
    ref_m[32'h300] = 64'h55;
    exp_last = 1'b1;
    for (int i = 0; i < 8; i++)
      burst(vt[i].preq, vt[i].creq, vt[i].pa, vt[i].pl, vt[i].ca, vt[i].cl, vt[i].mask, vt[i].dbase, vt[i].exp_cu, -1);
    burst(0, 1, 32'h0, 8'd0, 32'h10, 8'd7, 32'hFFFF_FFFF, 64'h0, 1'b1, 3);
    glb_enable = 1'b0; bus.ps_req = 1; bus.cu_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noen_state", state_out, 0);
      chk("noen_gnt", {bus.ps_gnt, bus.cu_gnt}, 0);
    end
    bus.ps_req = 0; bus.cu_req = 0; glb_enable = 1'b1;
    tick();
    bus.ps_req = 1; bus.ps_addr = 32'h100; bus.ps_len = 8'd7;
    tick();
    bus.ps_req = 0;
    chk("rst_gnt", state_out, 1);
    for (int i = 0; i < 2; i++) begin
      bus.ps_wvalid = 1; bus.ps_wdata = 64'hC0 + 64'(i);
      tick();
      chk("rst_beat_addr", bus.wm_addr, 32'h100 + i);
      ref_m[32'h100 + i] = 64'hC0 + 64'(i);
    end
    bus.ps_wdata = 64'hC2; reset = 1'b0;
    tick();
    chk_zero();
    reset = 1'b1; bus.ps_wvalid = 0; exp_last = 1'b1;
    burst(1, 1, 32'h100, 8'd1, 32'h0, 8'd0, 32'hFFFF_FFFF, 64'hD0, 1'b0, -1);
    burst(0, 1, 32'h0, 8'd0, 32'h100, 8'd2, 32'hFFFF_FFFF, 64'h0, 1'b1, -1);
    for (int it = 0; it < 60; it++) begin
      bit p, c, w;
      p = 1'($urandom % 2); c = 1'($urandom % 2);
      if (!p && !c) p = 1'b1;
      w = (p && c) ? !exp_last : c;
      burst(p, c, rnd_addr(), 8'($urandom % 6), rnd_addr(), 8'($urandom % 6), $urandom | $urandom,
            {$urandom, $urandom}, w, ($urandom % 5 == 0) ? int'($urandom % 8) : -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wmem_port_arbiter.md
Name: wmem_port_arbiter

Overview:
- Shares the single weight-memory port between two requesters: the PS-side weight loader (burst writes) and the control unit / LS array (burst reads for MXU weight fetch).
- Round-robin arbitration, burst-granular ownership, internal address generation, 1-cycle memory read-latency tracking.
- Sits between the weight memory and its two masters; the control unit no longer drives wm_ce/wm_we directly.

Parameters:
ADDRESS_SIZE_WMEMORY, 32, weight memory address width
DATA_WIDTH_WMEMORY, 64, weight memory data width
BURST_LEN_W, 8, width of burst length fields (beats-1 encoding)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
glb_enable  in  1  global enable; low aborts at next beat boundary
ps_req  in  1  PS write-burst request
ps_addr  in  ADDRESS_SIZE_WMEMORY  burst base address, sampled at grant
ps_len  in  BURST_LEN_W  beats-1, sampled at grant
ps_gnt  out  1  PS owns the port (level)
ps_wvalid  in  1  write beat valid
ps_wdata  in  DATA_WIDTH_WMEMORY  write beat data
ps_wready  out  1  beat accepted when ps_wvalid&&ps_wready
ps_done  out  1  1-cycle pulse, burst finished
cu_req  in  1  CU read-burst request
cu_addr  in  ADDRESS_SIZE_WMEMORY  burst base address, sampled at grant
cu_len  in  BURST_LEN_W  beats-1, sampled at grant
cu_gnt  out  1  CU owns the port (level)
cu_rdata  out  DATA_WIDTH_WMEMORY  read data
cu_rvalid  out  1  cu_rdata valid
cu_done  out  1  pulse coincident with last cu_rvalid
abort  out  1  1-cycle pulse, burst ended by glb_enable low
wm_ce  out  1  memory chip enable
wm_we  out  1  memory write enable
wm_addr  out  ADDRESS_SIZE_WMEMORY  memory address
wm_din  out  DATA_WIDTH_WMEMORY  memory write data
wm_dout  in  DATA_WIDTH_WMEMORY  memory read data, valid 1 cycle after read wm_ce
state_out  out  2  debug state

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; last_owner=CU, so PS wins the first tie; counters cleared. Reset mid-burst drops the burst; no done pulse.
- States: IDLE=0, OWN_PS=1, OWN_CU=2, DRAIN=3.
- IDLE: if glb_enable and any req, register base/len of the winner and go to OWN_x. gnt rises the cycle after req is sampled. Tie goes to the requester that is not last_owner. A single requester always wins.
- OWN_PS:
  - ps_wready = ps_gnt (combinational from state).
  - Each accepted beat registers wm_ce=1, wm_we=1, wm_addr=cur_addr, wm_din=ps_wdata into the next cycle, then cur_addr+1.
  - Bubbles (ps_wvalid=0) are allowed; wm_ce=0 on those cycles.
  - Last beat (beats_left==0) → IDLE. ps_gnt drops next cycle; ps_done pulses with the final wm_ce; last_owner=PS.
- OWN_CU:
  - One read issued per cycle: wm_ce=1, wm_we=0, wm_addr=cur_addr; no backpressure.
  - cu_rvalid/cu_rdata = wm_dout one cycle after each read wm_ce.
  - After the last issue → DRAIN; cu_gnt drops.
- DRAIN: wait for the last cu_rvalid (one cycle); cu_done pulses with it; → IDLE; last_owner=CU.
- Timing: CU burst len L granted at cycle G (cu_gnt high). Reads at G+1..G+L+1; rvalid at G+2..G+L+2.
- Address: cur_addr increments modulo 2^ADDRESS_SIZE_WMEMORY; wraps silently.
- Request deasserted mid-burst: ignored; the burst completes. req held after done → re-arbitrated in IDLE, with round-robin applied.
- glb_enable low in OWN_x:
  - The current beat, if any, completes; no further beats.
  - CU reads already issued still return rvalid.
  - abort pulses; the done pulse is suppressed; → IDLE (via DRAIN for CU).
- glb_enable low in IDLE: no grants.
- ps_gnt and cu_gnt are never both 1. wm_we=1 only when wm_ce=1.

Decomposition:
- Shared package/header: state encodings, owner IDs (OWN_ID_PS=0, OWN_ID_CU=1), BURST_LEN_W default.
- Sub-module wmem_burst_agen: loads base/len, increments the address on a step input, beats-left down-counter, last flag. Instantiated once, reloaded per grant.

Test Plan:
1. PS-only: ps_req, addr=0x10, len=3, wvalid continuous with data 0xA0..0xA3 → wm writes to 0x10..0x13 on 4 consecutive cycles; ps_done with the 4th; ps_gnt low after.
2. CU-only: cu_req, addr=0x10, len=3 after test 1 → cu_rdata 0xA0..0xA3 at G+2..G+5; cu_done with 0xA3; no wm_we.
3. Simultaneous req after reset: both asserted → PS granted first. Keep both asserted → CU next, then PS (alternation over 4 bursts, len=0 each).
4. Wrap and bubbles: PS addr=0xFFFFFFFE, len=3, wvalid pattern 1,0,1,1,1 → writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; wm_ce low during the bubble.
5. Abort: CU len=7; glb_enable low after 3 issued reads → all 3 rvalids return, abort pulses, no cu_done, IDLE; no grant while glb_enable=0.
6. Reset mid-burst: PS len=7, reset low after 2 beats → next cycle all outputs 0, state_out=0, no ps_done; a fresh PS burst then works normally.
